// File: rtl/wb_arb_ctrl.sv
// -----------------------------------------------------------------------------
// wb_arb_ctrl -- fixed-priority Wishbone bus arbiter with address decode and
// transfer watchdog.
//
// Four masters (m0 highest priority .. m3 lowest) compete for one shared bus.
// A grant is taken in IDLE and held, without preemption, for as long as the
// granted master keeps its cyc high. One RELEASE cycle of bus turnaround
// follows every grant, and then requests are re-arbitrated. While a master
// holds the bus, address bits [31:30] select one of three slaves. The fourth
// region is unmapped, and a strobe to it is answered with an arbiter error. A
// 10-bit wait counter ends any strobed beat that gets no ack/err from its slave
// within TIMEOUT cycles, and the arbiter then signals an error.
//
// Parameters
//   TIMEOUT      strobed cycles without a slave response before forced error
//                (2..1023)
// Ports
//   wb_clk       wishbone clock; all state changes on the rising edge
//   wb_rst_n     asynchronous active-low reset
//   m_cyc_i[3:0] master cyc requests, bit0 = m0 (VRAM) .. bit3 = m3 (DMA)
//   m_stb_i[3:0] master strobes
//   gnt_addr_i   address bits [31:30] of the granted master (datapath mux)
//   s_ack_i[2:0] slave acks: bit0 = RAM, bit1 = ROM, bit2 = IO
//   s_err_i[2:0] slave errors
//   grant_o      one-hot grant to the datapath mux, 0 when no master is granted
//   gnt_valid_o  a master holds the bus
//   slv_cyc_o    one-hot slave cyc
//   slv_stb_o    one-hot slave stb
//   arb_err_o    arbiter-generated error (decode miss or timeout), 1-cycle pulse
//   timeout_o    sticky: a timeout has occurred since reset
// -----------------------------------------------------------------------------
module wb_arb_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       wb_clk,
  input  logic       wb_rst_n,
  input  logic [3:0] m_cyc_i,
  input  logic [3:0] m_stb_i,
  input  logic [1:0] gnt_addr_i,
  input  logic [2:0] s_ack_i,
  input  logic [2:0] s_err_i,
  output logic [3:0] grant_o,
  output logic       gnt_valid_o,
  output logic [2:0] slv_cyc_o,
  output logic [2:0] slv_stb_o,
  output logic       arb_err_o,
  output logic       timeout_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS     = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam logic [9:0] TIMEOUT_W = 10'(TIMEOUT);

  state_e     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic       arb_err_q, arb_err_d;
  logic       timeout_q, timeout_d;
  logic [9:0] wait_q, wait_d;

  logic [3:0] lowest_req;
  logic       gnt_cyc;
  logic       gnt_stb;
  logic [2:0] slv_sel;
  logic       mapped;
  logic       slave_resp;

  // Isolate the lowest set request bit (x & -x), which is the m0-first priority.
  assign lowest_req = m_cyc_i & (~m_cyc_i + 4'd1);

  // grant_q is one-hot or zero, so these reduce to the granted master's bits.
  assign gnt_cyc = |(grant_q & m_cyc_i);
  assign gnt_stb = |(grant_q & m_cyc_i & m_stb_i);

  // Address decode of the granted master's top address bits.
  always_comb begin
    slv_sel = 3'b000;
    mapped  = 1'b1;
    case (gnt_addr_i)
      2'b00:   slv_sel = 3'b001;
      2'b01:   slv_sel = 3'b010;
      2'b10:   slv_sel = 3'b100;
      default: mapped  = 1'b0;
    endcase
  end

  // Only the selected slave's response counts; all other slaves are ignored.
  assign slave_resp = |(slv_sel & (s_ack_i | s_err_i));

  assign gnt_valid_o = (state_q == BUS);
  assign grant_o     = grant_q;
  assign slv_cyc_o   = gnt_valid_o ? slv_sel : 3'b000;
  assign slv_stb_o   = gnt_stb ? slv_cyc_o : 3'b000;
  assign arb_err_o   = arb_err_q;
  assign timeout_o   = timeout_q;

  // Next-state and next-register logic.
  // NOTE: every signal assigned here gets its default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    arb_err_d = 1'b0;
    timeout_d = timeout_q;
    wait_d    = 10'd0;

    case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          grant_d = lowest_req;
          state_d = BUS;
        end
      end

      BUS: begin
        // A cycle in which arb_err_o is high terminates the current beat. The
        // strobe seen in that cycle therefore belongs to the beat that already
        // errored, and it neither raises a new error nor starts a new count.
        if (gnt_stb && !arb_err_q) begin
          if (!mapped) begin
            arb_err_d = 1'b1;
          end else if (!slave_resp) begin
            // A slave response in the same cycle takes this branch away, so an
            // ack wins over a timeout that would otherwise fire.
            if (wait_q + 10'd1 == TIMEOUT_W) begin
              arb_err_d = 1'b1;
              timeout_d = 1'b1;
            end else begin
              wait_d = wait_q + 10'd1;
            end
          end
        end

        // The grant is held until the owner drops cyc. A higher-priority
        // request that arrives meanwhile waits for the next IDLE.
        if (!gnt_cyc) begin
          state_d = RELEASE;
          grant_d = 4'b0000;
          wait_d  = 10'd0;
        end
      end

      RELEASE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  // Every register here is a small control flop, so all of them get a reset
  // value and reset leaves no stale grant, error or count behind.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 4'b0000;
      arb_err_q <= 1'b0;
      timeout_q <= 1'b0;
      wait_q    <= 10'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      arb_err_q <= arb_err_d;
      timeout_q <= timeout_d;
      wait_q    <= wait_d;
    end
  end

endmodule

// File: tb/tb_wb_arb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_arb_ctrl -- self-checking bench for wb_arb_ctrl (TIMEOUT = 4).
//
// The reference model tracks the bus in transaction terms: which master owns
// the bus (or none), whether a turnaround cycle is pending, how long the
// current beat has waited, and any error that is due. Every cycle the bench
// compares all DUT outputs with the model on the falling edge.
// -----------------------------------------------------------------------------
module tb_wb_arb_ctrl;

  localparam int TO = 4;

  logic       wb_clk   = 1'b0;
  logic       wb_rst_n = 1'b0;
  logic [3:0] m_cyc    = 4'd0;
  logic [3:0] m_stb    = 4'd0;
  logic [1:0] addr     = 2'd0;
  logic [2:0] ack      = 3'd0;
  logic [2:0] err      = 3'd0;

  logic [3:0] grant;
  logic       gnt_valid;
  logic [2:0] slv_cyc;
  logic [2:0] slv_stb;
  logic       arb_err;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int owner;       // index of the master that owns the bus, -1 when none
  bit turnaround;  // the bus is in its post-grant gap cycle
  int waited;      // strobed cycles without a response in the current beat
  bit err_due;     // an arbiter error shows in the current cycle
  bit to_seen;     // a timeout has happened since reset

  wb_arb_ctrl #(.TIMEOUT(TO)) dut (
    .wb_clk      (wb_clk),
    .wb_rst_n    (wb_rst_n),
    .m_cyc_i     (m_cyc),
    .m_stb_i     (m_stb),
    .gnt_addr_i  (addr),
    .s_ack_i     (ack),
    .s_err_i     (err),
    .grant_o     (grant),
    .gnt_valid_o (gnt_valid),
    .slv_cyc_o   (slv_cyc),
    .slv_stb_o   (slv_stb),
    .arb_err_o   (arb_err),
    .timeout_o   (timeout)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    owner      = -1;
    turnaround = 1'b0;
    waited     = 0;
    err_due    = 1'b0;
    to_seen    = 1'b0;
  endtask

  // The owner's strobe counts only while the owner still holds cyc.
  function automatic bit owner_strobing();
    if (owner < 0) return 1'b0;
    return m_cyc[owner] && m_stb[owner];
  endfunction

  // Compare every DUT output with what the model expects for this cycle.
  task automatic check_all();
    logic [3:0] e_grant;
    logic [2:0] e_slv;
    e_grant = 4'd0;
    e_slv   = 3'd0;
    if (owner >= 0) begin
      e_grant = 4'(1 << owner);
      if (addr != 2'b11) e_slv = 3'(1 << addr);
    end
    chk("grant",     grant,     e_grant);
    chk("gnt_valid", gnt_valid, owner >= 0);
    chk("slv_cyc",   slv_cyc,   e_slv);
    chk("slv_stb",   slv_stb,   owner_strobing() ? e_slv : 3'd0);
    chk("arb_err",   arb_err,   err_due);
    chk("timeout",   timeout,   to_seen);
  endtask

  // Advance the model by one rising edge, using the inputs held before it.
  task automatic model_step();
    bit resp;
    bit next_err;
    next_err = 1'b0;
    if (owner >= 0) begin
      resp = (addr != 2'b11) && (ack[addr] || err[addr]);
      if (owner_strobing() && !err_due) begin
        if (addr == 2'b11) next_err = 1'b1;
        else if (resp) waited = 0;
        else if (waited + 1 == TO) begin
          next_err = 1'b1;
          to_seen  = 1'b1;
          waited   = 0;
        end else waited++;
      end else waited = 0;
      if (!m_cyc[owner]) begin
        owner      = -1;
        turnaround = 1'b1;
        waited     = 0;
      end
    end else if (turnaround) begin
      turnaround = 1'b0;
    end else begin
      for (int i = 3; i >= 0; i--) if (m_cyc[i]) owner = i;
    end
    err_due = next_err;
  endtask

  task automatic set_in(input logic [3:0] c, input logic [3:0] s, input logic [1:0] a,
                        input logic [2:0] k, input logic [2:0] e);
    m_cyc = c;
    m_stb = s;
    addr  = a;
    ack   = k;
    err   = e;
  endtask

  // One bus cycle: apply the inputs, check outputs mid-cycle, then clock the edge.
  task automatic cycle(input logic [3:0] c, input logic [3:0] s, input logic [1:0] a,
                       input logic [2:0] k, input logic [2:0] e);
    set_in(c, s, a, k, e);
    @(negedge wb_clk);
    check_all();
    @(posedge wb_clk);
    model_step();
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(4'b0000, 4'b0000, 2'b00, 3'b000, 3'b000);
  endtask

  initial begin
    model_reset();
    #2;
    check_all();                     // reset state
    @(posedge wb_clk);
    #1 wb_rst_n = 1'b1;
    idle_cycles(2);

    // m2 and m3 request together: m2 wins and IO is selected. The ack comes
    // after two waiting cycles, and then m3 gets its turn after the turnaround.
    cycle(4'b1100, 4'b1100, 2'b10, 3'b000, 3'b000);
    cycle(4'b1100, 4'b1100, 2'b10, 3'b000, 3'b000);
    cycle(4'b1100, 4'b1100, 2'b10, 3'b000, 3'b000);
    cycle(4'b1100, 4'b1100, 2'b10, 3'b100, 3'b000);
    cycle(4'b1000, 4'b1000, 2'b10, 3'b000, 3'b000);
    cycle(4'b1000, 4'b0000, 2'b10, 3'b000, 3'b000);
    cycle(4'b1000, 4'b1000, 2'b10, 3'b100, 3'b000);
    idle_cycles(3);

    // m1 runs a 4-beat burst. m0 raises cyc at beat 2 and gets no preemption.
    cycle(4'b0010, 4'b0010, 2'b01, 3'b000, 3'b000);
    cycle(4'b0010, 4'b0010, 2'b01, 3'b010, 3'b000);
    cycle(4'b0011, 4'b0011, 2'b01, 3'b010, 3'b000);
    cycle(4'b0011, 4'b0011, 2'b01, 3'b010, 3'b000);
    cycle(4'b0011, 4'b0011, 2'b01, 3'b010, 3'b000);
    cycle(4'b0001, 4'b0001, 2'b00, 3'b000, 3'b000);
    cycle(4'b0001, 4'b0001, 2'b00, 3'b000, 3'b000);
    cycle(4'b0001, 4'b0001, 2'b00, 3'b000, 3'b000);
    cycle(4'b0001, 4'b0001, 2'b00, 3'b001, 3'b000);
    idle_cycles(3);

    // Unmapped region: a single strobe first, then a held strobe.
    cycle(4'b0100, 4'b0000, 2'b11, 3'b000, 3'b000);
    cycle(4'b0100, 4'b0100, 2'b11, 3'b000, 3'b000);
    cycle(4'b0100, 4'b0000, 2'b11, 3'b000, 3'b000);
    cycle(4'b0100, 4'b0000, 2'b11, 3'b000, 3'b000);
    for (int i = 0; i < 4; i++) cycle(4'b0100, 4'b0100, 2'b11, 3'b111, 3'b000);
    idle_cycles(3);

    // The ack arrives on the cycle the count would reach TIMEOUT. Acks from
    // non-selected slaves must not clear the count.
    cycle(4'b0001, 4'b0001, 2'b00, 3'b000, 3'b000);
    cycle(4'b0001, 4'b0001, 2'b00, 3'b010, 3'b000);
    cycle(4'b0001, 4'b0001, 2'b00, 3'b100, 3'b100);
    cycle(4'b0001, 4'b0001, 2'b00, 3'b000, 3'b010);
    cycle(4'b0001, 4'b0001, 2'b00, 3'b001, 3'b000);
    cycle(4'b0001, 4'b0001, 2'b00, 3'b000, 3'b000);
    cycle(4'b0001, 4'b0001, 2'b00, 3'b000, 3'b000);
    idle_cycles(3);

    // Timeout on RAM with no ack. timeout_o must then stay set.
    cycle(4'b0001, 4'b0001, 2'b00, 3'b000, 3'b000);
    for (int i = 0; i < 7; i++) cycle(4'b0001, 4'b0001, 2'b00, 3'b110, 3'b000);
    cycle(4'b0001, 4'b0000, 2'b00, 3'b000, 3'b000);
    idle_cycles(3);

    // Reset asserted between edges in the middle of an m2 burst, with m3
    // pending. After release, m3 is granted from IDLE.
    cycle(4'b1100, 4'b0100, 2'b01, 3'b000, 3'b000);
    cycle(4'b1100, 4'b0100, 2'b01, 3'b000, 3'b000);
    cycle(4'b1100, 4'b0100, 2'b01, 3'b000, 3'b000);
    #2 wb_rst_n = 1'b0;
    model_reset();
    #1 check_all();                  // outputs cleared without a clock edge
    set_in(4'b1000, 4'b1000, 2'b01, 3'b000, 3'b000);
    @(posedge wb_clk);
    #1 wb_rst_n = 1'b1;
    cycle(4'b1000, 4'b1000, 2'b01, 3'b000, 3'b000);
    cycle(4'b1000, 4'b1000, 2'b01, 3'b000, 3'b000);
    cycle(4'b1000, 4'b1000, 2'b01, 3'b010, 3'b000);
    idle_cycles(3);

    // Random traffic: requests change only now and then, so the grants last
    // over several cycles. Slave responses are sparse enough for timeouts.
    begin
      logic [3:0] rc;
      rc = 4'd0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 4) == 0) rc = 4'($urandom_range(0, 15));
        cycle(rc, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
              3'($urandom_range(0, 7) & $urandom_range(0, 7) & $urandom_range(0, 7)),
              ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'd0);
      end
    end
    idle_cycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arb_ctrl.md
WB_ARB_CTRL -- requirements
Module: wb_arb_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT, 255, cycles a strobed transfer may wait for slave ack/err before forced error (range 2..1023).
REQ-002 SHALL have ports (name  direction  width  meaning):
 wb_clk  in  1  wishbone clock, all state on rising edge
 wb_rst_n  in  1  asynchronous active-low reset
 m_cyc_i  in  4  master cyc requests, bit0 = m0 (VRAM) .. bit3 = m3 (DMA)
 m_stb_i  in  4  master strobes
 gnt_addr_i  in  2  address bits [31:30] of the granted master, from datapath mux
 s_ack_i  in  3  slave acks, bit0 = s0 RAM, bit1 = s1 ROM, bit2 = s2 IO
 s_err_i  in  3  slave errors
 grant_o  out  4  one-hot grant to datapath mux, 0 when idle
 gnt_valid_o  out  1  a master holds the bus
 slv_cyc_o  out  3  one-hot slave cyc
 slv_stb_o  out  3  one-hot slave stb
 arb_err_o  out  1  arbiter-generated error to granted master (decode or timeout)
 timeout_o  out  1  sticky flag: a timeout has occurred since reset

Function
REQ-003 SHALL implement FSM states IDLE, BUS, RELEASE.
REQ-004 IDLE: if m_cyc_i != 0, SHALL register grant_o to the lowest-numbered asserted bit (m0 > m1 > m2 > m3) and go to BUS at the next edge; else stay.
REQ-005 Grant latency SHALL be exactly 1 cycle: cyc seen at edge N, grant_o/gnt_valid_o high after edge N.
REQ-006 BUS: grant SHALL be held, without preemption by higher-priority masters, while the granted master's m_cyc_i bit is high, including across burst beats.
REQ-007 BUS: granted cyc low SHALL move to RELEASE; grant_o cleared at that edge.
REQ-008 RELEASE SHALL last exactly 1 cycle (bus turnaround) then go to IDLE; requests are re-arbitrated in IDLE.
REQ-009 Address decode, combinational in BUS: gnt_addr_i 2'b00 -> s0, 2'b01 -> s1, 2'b10 -> s2, 2'b11 -> unmapped.
REQ-010 slv_cyc_o SHALL be the decoded one-hot when gnt_valid_o is high and mapped, else 0.
REQ-011 slv_stb_o SHALL equal slv_cyc_o gated by the granted master's m_stb_i bit.
REQ-012 Unmapped with granted stb high SHALL assert arb_err_o for exactly one cycle, starting the cycle after stb is seen; repeats for each further strobed beat.
REQ-013 A 10-bit wait counter SHALL increment each BUS cycle with granted stb high and no ack/err from the selected slave; it clears on ack, err, stb low or leaving BUS.
REQ-014 Counter reaching TIMEOUT SHALL assert arb_err_o for one cycle, set timeout_o, clear the counter; grant remains until master drops cyc.
REQ-015 s_ack_i/s_err_i bits of non-selected slaves SHALL be ignored.
REQ-016 Ack and TIMEOUT on the same cycle: ack wins, no arb_err_o.
REQ-017 All requests simultaneous in IDLE: m0 granted; others wait in priority order across successive releases.
REQ-018 Granted master dropping cyc in the same cycle a higher master raises cyc: normal RELEASE, then higher master wins in IDLE.

Reset
REQ-019 wb_rst_n low SHALL immediately, independent of wb_clk, force state IDLE, grant_o=0, gnt_valid_o=0, slv_cyc_o=0, slv_stb_o=0, arb_err_o=0, timeout_o=0, counter=0.
REQ-020 Reset asserted mid-transfer SHALL abort the grant; after deassertion the FSM arbitrates from IDLE with no residual error.
REQ-021 Deassertion SHALL be sampled on wb_clk; first grant no earlier than the edge after deassertion.

Verification
REQ-022 m_cyc_i=4'b1100, gnt_addr_i=2'b10, stb high, s_ack_i=3'b100 after 2 cycles -> grant_o=4'b0100 one cycle later, slv_stb_o=3'b100, no arb_err_o.
REQ-023 m1 in 4-beat burst, m0 raises cyc at beat 2 -> grant_o stays 4'b0010 until m1 cyc low, 1 RELEASE cycle, then 4'b0001.
REQ-024 gnt_addr_i=2'b11, stb high -> slv_cyc_o=0, arb_err_o single-cycle pulse the cycle after stb.
REQ-025 TIMEOUT=4, mapped s0, no ack -> arb_err_o pulse after 4 strobed cycles, timeout_o=1 until reset.
REQ-026 wb_rst_n low mid-burst between clock edges -> all outputs 0 immediately; after release, pending m3 granted from IDLE.
REQ-027 Ack on the same cycle the counter hits TIMEOUT -> no arb_err_o, timeout_o unchanged.
